clk_freq_mon: RTL and testbench



---
 rtl/clk_freq_mon.sv | 125 ++++++++++++
 tb/tb_clk_freq_mon.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_mon.sv
// Counts rising edges of an asynchronous clk_in over a fixed window of sys_clk cycles.
// Optional macro CLK_FREQ_MON_CONT_EN re-arms after every result for continuous monitoring.
`timescale 1ns/1ps
module clk_freq_mon #(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned GATE_W      = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clk_in,
    input  logic             start,
    input  logic [CNT_W-1:0] exp_min,
    input  logic [CNT_W-1:0] exp_max,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             freq_ok,
    output logic             stuck,
    output logic             sat
);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeasure,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0]  CntMax   = '1;
    localparam logic [GATE_W-1:0] GateLast = GATE_W'(GATE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        sync_q;
    logic [GATE_W-1:0] gate_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              sat_w_q;
    logic              rise;
    logic              gate_last;

    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  edge_cnt_q;
    logic              freq_ok_q;
    logic              stuck_q;
    logic              sat_q;

    // sync_q[1] is the synchronized level, sync_q[2] its one-cycle delayed copy
    assign rise      = sync_q[1] & ~sync_q[2];
    assign gate_last = (gate_q == GateLast);
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StArm;
            StArm:     state_d = StMeasure;
            StMeasure: if (gate_last) state_d = StDone;
`ifdef CLK_FREQ_MON_CONT_EN
            StDone:    state_d = StArm;
`else
            StDone:    state_d = StIdle;
`endif
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q     <= '0;
            gate_q     <= '0;
            cnt_q      <= '0;
            sat_w_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            edge_cnt_q <= '0;
            freq_ok_q  <= 1'b0;
            stuck_q    <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], clk_in};
            // Registered from next state so busy tracks the FSM exactly
            busy_q <= (state_d != StIdle);
            done_q <= (state_q == StDone);
            case (state_q)
                StArm: begin
                    gate_q  <= '0;
                    cnt_q   <= '0;
                    sat_w_q <= 1'b0;
                end
                StMeasure: begin
                    gate_q <= gate_q + GATE_W'(1);
                    if (rise && (cnt_q != CntMax)) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CntMax) sat_w_q <= 1'b1;
                    end
                end
                StDone: begin
                    edge_cnt_q <= cnt_q;
                    sat_q      <= sat_w_q;
                    stuck_q    <= (cnt_q == '0);
                    freq_ok_q  <= !sat_w_q && (cnt_q >= exp_min) && (cnt_q <= exp_max);
                end
                default: ;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign edge_cnt = edge_cnt_q;
    assign freq_ok  = freq_ok_q;
    assign stuck    = stuck_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_clk_freq_mon.sv
// Directed bench for clk_freq_mon: a 16-bit instance for the main checks and an 8-bit,
// 1100-cycle-gate instance that is driven past its count limit.
`timescale 1ns/1ps
module tb_clk_freq_mon;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        clk_gen   = 1'b0;
    logic        clk_en    = 1'b0;
    logic        start     = 1'b0;
    logic        clk_in;
    logic [15:0] exp_min   = '0;
    logic [15:0] exp_max   = '0;
    logic [7:0]  sat_min   = 8'd0;
    logic [7:0]  sat_max   = 8'd255;

    logic        busy, done, freq_ok, stuck, sat;
    logic [15:0] edge_cnt;
    logic        s_busy, s_done, s_freq_ok, s_stuck, s_sat;
    logic [7:0]  s_edge_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #10 sys_clk = ~sys_clk;
    // 80 ns clk_in, phase-offset from sys_clk so edges never coincide
    initial begin
        #7;
        forever #40 clk_gen = ~clk_gen;
    end
    assign clk_in = clk_gen & clk_en;

    clk_freq_mon #(.GATE_CYCLES(1000), .CNT_W(16), .GATE_W(16)) u_dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .clk_in   (clk_in),
        .start    (start),
        .exp_min  (exp_min),
        .exp_max  (exp_max),
        .busy     (busy),
        .done     (done),
        .edge_cnt (edge_cnt),
        .freq_ok  (freq_ok),
        .stuck    (stuck),
        .sat      (sat)
    );

    clk_freq_mon #(.GATE_CYCLES(1100), .CNT_W(8), .GATE_W(16)) u_dut_sat (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .clk_in   (clk_in),
        .start    (start),
        .exp_min  (sat_min),
        .exp_max  (sat_max),
        .busy     (s_busy),
        .done     (s_done),
        .edge_cnt (s_edge_cnt),
        .freq_ok  (s_freq_ok),
        .stuck    (s_stuck),
        .sat      (s_sat)
    );

    typedef struct {
        bit          en;
        logic [15:0] mn;
        logic [15:0] mx;
        int          lo;
        int          hi;
        bit          ok;
        bit          stk;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo,
                           input longint hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic pulse_start();
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    // Cycles from the start-sampling edge to the first done; -1 on timeout
    task automatic wait_done(input bit use_sat, input int max_cyc, output int lat);
        lat = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge sys_clk);
            #1;
            if (use_sat ? s_done : done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        clk_en  = v.en;
        exp_min = v.mn;
        exp_max = v.mx;
        repeat (20) @(posedge sys_clk);
        pulse_start();
        wait_done(1'b0, 1200, lat);
        chk({tag, " latency"}, lat, 1002);
        chk_rng({tag, " edge_cnt"}, edge_cnt, v.lo, v.hi);
        chk({tag, " freq_ok"}, freq_ok, v.ok);
        chk({tag, " stuck"}, stuck, v.stk);
        chk({tag, " sat"}, sat, 0);
        chk({tag, " busy_after"}, busy, 0);
        @(posedge sys_clk);
        #1;
        chk({tag, " done_1cyc"}, done, 0);
    endtask

    initial begin
        int lat;
        int dones;
        int first;

        vecs[0] = '{en: 1, mn: 249, mx: 251, lo: 249, hi: 251, ok: 1, stk: 0};
        vecs[1] = '{en: 0, mn: 249, mx: 251, lo: 0,   hi: 0,   ok: 0, stk: 1};
        vecs[2] = '{en: 0, mn: 0,   mx: 0,   lo: 0,   hi: 0,   ok: 1, stk: 1};
        vecs[3] = '{en: 1, mn: 251, mx: 249, lo: 249, hi: 251, ok: 0, stk: 0};
        vecs[4] = '{en: 1, mn: 0,   mx: 248, lo: 249, hi: 251, ok: 0, stk: 0};
        vecs[5] = '{en: 1, mn: 252, mx: 300, lo: 249, hi: 251, ok: 0, stk: 0};

        #5 sys_rst_n = 1'b0;
        repeat (5) @(posedge sys_clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst edge_cnt", edge_cnt, 0);
        chk("rst freq_ok", freq_ok, 0);
        chk("rst stuck", stuck, 0);
        chk("rst sat", sat, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // 275 edges in an 1100-cycle gate overflow the 8-bit counter
        clk_en = 1'b1;
        repeat (20) @(posedge sys_clk);
        pulse_start();
        wait_done(1'b1, 1300, lat);
        chk("sat latency", lat, 1102);
        chk("sat edge_cnt", s_edge_cnt, 255);
        chk("sat sat", s_sat, 1);
        chk("sat freq_ok", s_freq_ok, 0);
        chk("sat stuck", s_stuck, 0);

`ifdef CLK_FREQ_MON_CONT_EN
        begin
            int t[3];
            int busy_low;
            @(negedge sys_clk);
            sys_rst_n = 1'b0;
            repeat (3) @(posedge sys_clk);
            @(negedge sys_clk);
            sys_rst_n = 1'b1;
            exp_min  = 16'd249;
            exp_max  = 16'd251;
            repeat (20) @(posedge sys_clk);
            pulse_start();
            dones    = 0;
            busy_low = 0;
            for (int c = 1; c <= 3100; c++) begin
                @(posedge sys_clk);
                #1;
                if (!busy) busy_low++;
                if (done) begin
                    if (dones < 3) t[dones] = c;
                    dones++;
                    chk_rng("cont edge_cnt", edge_cnt, 249, 251);
                    chk("cont freq_ok", freq_ok, 1);
                end
            end
            chk("cont done count", dones, 3);
            chk("cont done1", t[0], 1002);
            chk("cont done2", t[1], 2004);
            chk("cont done3", t[2], 3006);
            chk("cont busy_low", busy_low, 0);
        end
`else
        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Second start mid-measurement must be dropped
        clk_en  = 1'b1;
        exp_min = 16'd249;
        exp_max = 16'd251;
        repeat (20) @(posedge sys_clk);
        pulse_start();
        dones = 0;
        first = -1;
        for (int c = 1; c <= 2300; c++) begin
            @(posedge sys_clk);
            #1;
            if (c == 102) start = 1'b1;
            if (c == 103) start = 1'b0;
            if (done) begin
                dones++;
                if (first < 0) first = c;
            end
        end
        chk("ign done count", dones, 1);
        chk("ign done time", first, 1002);
        chk("ign busy_after", busy, 0);

        // Reset 500 cycles into MEASURE, outputs previously non-zero
        pulse_start();
        repeat (501) @(posedge sys_clk);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst edge_cnt", edge_cnt, 0);
        chk("midrst freq_ok", freq_ok, 0);
        chk("midrst done", done, 0);
        chk("midrst stuck", stuck, 0);
        chk("midrst sat", sat, 0);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_done(1'b0, 1100, lat);
        chk("midrst no_done", lat, -1);
        run_vec("post_rst", vecs[0]);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
